hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage RV64I/Zba core. It sits beside the decode stage and the ID/EX, EX/MEM and MEM/WB registers. It generates the operand-forwarding selects, the load-use stall, the branch/jump flushes, and a freeze for multi-cycle execute operations. Only the FSM, the watchdog and the optional counters hold state; all other logic is combinational.

---
 rtl/pipe_pkg.sv | 31 +++
 rtl/hazard_fwd.sv | 21 ++
 rtl/hazard_ctrl.sv | 145 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants for the RV64I/Zba core.
// Forward selects, result-source encodings and hazard FSM states.
package pipe_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  typedef enum logic {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } mc_state_t;

  // Memory beats Writeback; x0 never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic       we_m,
    input logic [4:0] rd_w,
    input logic       we_w
  );
    if (we_m && rd_m != 5'd0 && rd_m == rs)
      return FWD_M;
    if (we_w && rd_w != 5'd0 && rd_w == rs)
      return FWD_W;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_fwd.sv
// Combinational operand-forwarding selects for the Execute stage.
// Ports: Rs1_E/Rs2_E, Rd_M/Rd_W, RegWrite_M/W in; ForwardA_E/B_E out.
module hazard_fwd
  import pipe_pkg::*;
(
  input  logic [4:0] Rs1_E,
  input  logic [4:0] Rs2_E,
  input  logic [4:0] Rd_M,
  input  logic [4:0] Rd_W,
  input  logic       RegWrite_M,
  input  logic       RegWrite_W,
  output logic [1:0] ForwardA_E,
  output logic [1:0] ForwardB_E
);

  assign ForwardA_E = fwd_sel(Rs1_E, Rd_M, RegWrite_M,
                              Rd_W, RegWrite_W);
  assign ForwardB_E = fwd_sel(Rs2_E, Rd_M, RegWrite_M,
                              Rd_W, RegWrite_W);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use stall, flushes,
// multi-cycle freeze with watchdog and optional perf counters.
// Ports: clk, rst (sync, active-high); Decode/Execute/Memory/WB
// register ids and enables; PCSrc_E, McStart_E, McDone in;
// ForwardA_E/B_E, Stall_F/D/E, Flush_D/E/M, McTimeout,
// StallCnt/FlushCnt out. Counters built only with HAZARD_PERF_CNT_EN.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1_D,
  input  logic [4:0]       Rs2_D,
  input  logic [4:0]       Rs1_E,
  input  logic [4:0]       Rs2_E,
  input  logic [4:0]       Rd_E,
  input  logic [1:0]       ResultSrc_E,
  input  logic [4:0]       Rd_M,
  input  logic [4:0]       Rd_W,
  input  logic             RegWrite_M,
  input  logic             RegWrite_W,
  input  logic             PCSrc_E,
  input  logic             McStart_E,
  input  logic             McDone,
  output logic [1:0]       ForwardA_E,
  output logic [1:0]       ForwardB_E,
  output logic             Stall_F,
  output logic             Stall_D,
  output logic             Stall_E,
  output logic             Flush_D,
  output logic             Flush_E,
  output logic             Flush_M,
  output logic             McTimeout,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  localparam int WD_W = $clog2(MC_TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MC_TIMEOUT - 1);

  mc_state_t       state;
  logic [WD_W-1:0] wd_cnt;
  logic            timeout_q;
  logic [1:0]      fwd_a;
  logic [1:0]      fwd_b;
  logic            lw_stall;
  logic            mc_stall;
  logic            trip;

  hazard_fwd u_fwd (
    .Rs1_E      (Rs1_E),
    .Rs2_E      (Rs2_E),
    .Rd_M       (Rd_M),
    .Rd_W       (Rd_W),
    .RegWrite_M (RegWrite_M),
    .RegWrite_W (RegWrite_W),
    .ForwardA_E (fwd_a),
    .ForwardB_E (fwd_b)
  );

  assign ForwardA_E = rst ? FWD_RF : fwd_a;
  assign ForwardB_E = rst ? FWD_RF : fwd_b;

  assign lw_stall = (ResultSrc_E == RESULT_SRC_LOAD)
                 && (Rd_E != 5'd0)
                 && (Rd_E == Rs1_D || Rd_E == Rs2_D);

  assign trip = (state == MC_WAIT)
             && (wd_cnt == WD_LAST)
             && !McDone;

  // A k=1 op (McDone alongside McStart_E) never stalls.
  assign mc_stall =
      ((state == RUN) && McStart_E && !McDone)
   || ((state == MC_WAIT) && !McDone && !trip);

  always_comb begin
    Stall_F = 1'b0;
    Stall_D = 1'b0;
    Stall_E = 1'b0;
    Flush_D = 1'b1;
    Flush_E = 1'b1;
    Flush_M = 1'b0;
    if (!rst) begin
      Stall_F = lw_stall | mc_stall;
      Stall_D = lw_stall | mc_stall;
      Stall_E = mc_stall;
      Flush_M = mc_stall;
      Flush_D = PCSrc_E & ~mc_stall;
      Flush_E = (lw_stall | PCSrc_E) & ~mc_stall;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_q | trip;
      unique case (1'b1)
        (state == RUN): begin
          wd_cnt <= '0;
          if (McStart_E && !McDone)
            state <= MC_WAIT;
        end
        (state == MC_WAIT): begin
          wd_cnt <= wd_cnt + WD_W'(1);
          if (McDone || trip)
            state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  assign McTimeout = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (Stall_F && !(&stall_cnt))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if ((Flush_D || Flush_E) && !(&flush_cnt))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign StallCnt = stall_cnt;
  assign FlushCnt = flush_cnt;
`else
  assign StallCnt = '0;
  assign FlushCnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (MC_TIMEOUT=8).
// Scoreboard queues hold expected outputs until sampled.
module tb_hazard_ctrl;
  import pipe_pkg::*;

  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E;
  logic [1:0]       ResultSrc_E;
  logic [4:0]       Rd_M, Rd_W;
  logic             RegWrite_M, RegWrite_W;
  logic             PCSrc_E, McStart_E, McDone;
  logic [1:0]       ForwardA_E, ForwardB_E;
  logic             Stall_F, Stall_D, Stall_E;
  logic             Flush_D, Flush_E, Flush_M;
  logic             McTimeout;
  logic [CNT_W-1:0] StallCnt, FlushCnt;

  int total = 0;
  int bad   = 0;

  logic [10:0] sb[$];
  int          cq[$];

  always #5 clk = ~clk;

  hazard_ctrl #(.MC_TIMEOUT(8), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .Rs1_D       (Rs1_D),
    .Rs2_D       (Rs2_D),
    .Rs1_E       (Rs1_E),
    .Rs2_E       (Rs2_E),
    .Rd_E        (Rd_E),
    .ResultSrc_E (ResultSrc_E),
    .Rd_M        (Rd_M),
    .Rd_W        (Rd_W),
    .RegWrite_M  (RegWrite_M),
    .RegWrite_W  (RegWrite_W),
    .PCSrc_E     (PCSrc_E),
    .McStart_E   (McStart_E),
    .McDone      (McDone),
    .ForwardA_E  (ForwardA_E),
    .ForwardB_E  (ForwardB_E),
    .Stall_F     (Stall_F),
    .Stall_D     (Stall_D),
    .Stall_E     (Stall_E),
    .Flush_D     (Flush_D),
    .Flush_E     (Flush_E),
    .Flush_M     (Flush_M),
    .McTimeout   (McTimeout),
    .StallCnt    (StallCnt),
    .FlushCnt    (FlushCnt)
  );

  function automatic logic [10:0] ev(
    input logic [1:0] fa, input logic [1:0] fb,
    input logic s, input logic se, input logic fd,
    input logic fe, input logic fm, input logic to
  );
    return {fa, fb, s, s, se, fd, fe, fm, to};
  endfunction

  function automatic logic [10:0] obs();
    return {ForwardA_E, ForwardB_E, Stall_F, Stall_D, Stall_E,
            Flush_D, Flush_E, Flush_M, McTimeout};
  endfunction

  task automatic idle();
    rst = 1'b0;
    Rs1_D = '0; Rs2_D = '0; Rs1_E = '0; Rs2_E = '0; Rd_E = '0;
    ResultSrc_E = 2'b00; Rd_M = '0; Rd_W = '0;
    RegWrite_M = 1'b0; RegWrite_W = 1'b0;
    PCSrc_E = 1'b0; McStart_E = 1'b0; McDone = 1'b0;
  endtask

  task automatic set_fwd(
    input logic [4:0] r1, input logic [4:0] r2,
    input logic [4:0] rm, input logic wm,
    input logic [4:0] rw, input logic ww
  );
    Rs1_E = r1; Rs2_E = r2;
    Rd_M = rm; RegWrite_M = wm;
    Rd_W = rw; RegWrite_W = ww;
  endtask

  task automatic set_lu(
    input logic [1:0] src, input logic [4:0] rd,
    input logic [4:0] r1, input logic [4:0] r2
  );
    ResultSrc_E = src; Rd_E = rd; Rs1_D = r1; Rs2_D = r2;
  endtask

  task automatic test_reset();
    logic [10:0] e;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1; idle();
      case (i)
        0: begin
          rst = 1'b1;
          set_fwd(5'd5, 5'd5, 5'd5, 1'b1, 5'd5, 1'b1);
          set_lu(2'b01, 5'd7, 5'd7, 5'd7);
          PCSrc_E = 1'b1; McStart_E = 1'b1;
          sb.push_back(ev(FWD_RF, FWD_RF, 0, 0, 1, 1, 0, 0));
        end
        default: begin
          sb.push_back(ev(FWD_RF, FWD_RF, 0, 0, 0, 0, 0, 0));
          cq.push_back(0); cq.push_back(0);
        end
      endcase
      @(negedge clk);
      e = sb.pop_front(); total++;
      if (obs() !== e) begin
        bad++;
        $display("FAIL reset[%0d] got=%b exp=%b", i, obs(), e);
      end
    end
    total++;
    if (StallCnt !== CNT_W'(cq[0]) || FlushCnt !== CNT_W'(cq[1])) begin
      bad++;
      $display("FAIL reset_cnt got=%0d/%0d exp=%0d/%0d",
               StallCnt, FlushCnt, cq[0], cq[1]);
    end
    cq.delete();
  endtask

  task automatic test_forward();
    logic [10:0] e;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1; idle();
      case (i)
        0: begin
          set_fwd(5'd5, 5'd0, 5'd5, 1'b1, 5'd5, 1'b1);
          sb.push_back(ev(FWD_M, FWD_RF, 0, 0, 0, 0, 0, 0));
        end
        1: begin
          set_fwd(5'd5, 5'd0, 5'd0, 1'b1, 5'd5, 1'b1);
          sb.push_back(ev(FWD_W, FWD_RF, 0, 0, 0, 0, 0, 0));
        end
        2: begin
          set_fwd(5'd5, 5'd5, 5'd5, 1'b0, 5'd5, 1'b1);
          sb.push_back(ev(FWD_W, FWD_W, 0, 0, 0, 0, 0, 0));
        end
        3: begin
          set_fwd(5'd5, 5'd5, 5'd5, 1'b0, 5'd5, 1'b0);
          sb.push_back(ev(FWD_RF, FWD_RF, 0, 0, 0, 0, 0, 0));
        end
        4: begin
          set_fwd(5'd3, 5'd9, 5'd9, 1'b1, 5'd3, 1'b1);
          sb.push_back(ev(FWD_W, FWD_M, 0, 0, 0, 0, 0, 0));
        end
        default: begin
          set_fwd(5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
          sb.push_back(ev(FWD_RF, FWD_RF, 0, 0, 0, 0, 0, 0));
        end
      endcase
      @(negedge clk);
      e = sb.pop_front(); total++;
      if (obs() !== e) begin
        bad++;
        $display("FAIL fwd[%0d] got=%b exp=%b", i, obs(), e);
      end
    end
  endtask

  task automatic test_load_use();
    logic [10:0] e;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1; idle();
      case (i)
        0: begin
          set_lu(2'b01, 5'd7, 5'd0, 5'd7);
          sb.push_back(ev(0, 0, 1, 0, 0, 1, 0, 0));
        end
        2: begin
          set_lu(2'b01, 5'd7, 5'd7, 5'd2);
          sb.push_back(ev(0, 0, 1, 0, 0, 1, 0, 0));
        end
        3: begin
          set_lu(2'b01, 5'd0, 5'd0, 5'd0);
          sb.push_back(ev(0, 0, 0, 0, 0, 0, 0, 0));
        end
        4: begin
          set_lu(2'b10, 5'd7, 5'd0, 5'd7);
          sb.push_back(ev(0, 0, 0, 0, 0, 0, 0, 0));
        end
        5: begin
          set_lu(2'b01, 5'd7, 5'd3, 5'd4);
          sb.push_back(ev(0, 0, 0, 0, 0, 0, 0, 0));
        end
        default:
          sb.push_back(ev(0, 0, 0, 0, 0, 0, 0, 0));
      endcase
      @(negedge clk);
      e = sb.pop_front(); total++;
      if (obs() !== e) begin
        bad++;
        $display("FAIL loaduse[%0d] got=%b exp=%b", i, obs(), e);
      end
    end
  endtask

  task automatic test_branch();
    logic [10:0] e;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1; idle();
      case (i)
        0: begin
          PCSrc_E = 1'b1;
          sb.push_back(ev(0, 0, 0, 0, 1, 1, 0, 0));
        end
        1: begin
          PCSrc_E = 1'b1;
          set_lu(2'b01, 5'd4, 5'd4, 5'd0);
          sb.push_back(ev(0, 0, 1, 0, 1, 1, 0, 0));
        end
        default:
          sb.push_back(ev(0, 0, 0, 0, 0, 0, 0, 0));
      endcase
      @(negedge clk);
      e = sb.pop_front(); total++;
      if (obs() !== e) begin
        bad++;
        $display("FAIL branch[%0d] got=%b exp=%b", i, obs(), e);
      end
    end
  endtask

  task automatic test_multicycle();
    logic [10:0] e;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1; idle();
      if (i < 5) McStart_E = 1'b1;
      if (i == 1) set_lu(2'b01, 5'd6, 5'd6, 5'd0);
      if (i == 2) PCSrc_E = 1'b1;
      if (i == 4) McDone = 1'b1;
      if (i < 4)
        sb.push_back(ev(0, 0, 1, 1, 0, 0, 1, 0));
      else
        sb.push_back(ev(0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      e = sb.pop_front(); total++;
      if (obs() !== e) begin
        bad++;
        $display("FAIL mc[%0d] got=%b exp=%b", i, obs(), e);
      end
    end
  endtask

  task automatic test_k1();
    logic [10:0] e;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1; idle();
      if (i == 0) begin McStart_E = 1'b1; McDone = 1'b1; end
      if (i == 2) McDone = 1'b1;
      sb.push_back(ev(0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      e = sb.pop_front(); total++;
      if (obs() !== e) begin
        bad++;
        $display("FAIL k1[%0d] got=%b exp=%b", i, obs(), e);
      end
    end
  endtask

  task automatic test_watchdog();
    logic [10:0] e;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1; idle();
      if (i < 8) begin
        McStart_E = 1'b1;
        sb.push_back(ev(0, 0, 1, 1, 0, 0, 1, 0));
      end else if (i == 8) begin
        sb.push_back(ev(0, 0, 0, 0, 0, 0, 0, 0));
      end else if (i == 9) begin
        sb.push_back(ev(0, 0, 0, 0, 0, 0, 0, 1));
      end else if (i == 10) begin
        McStart_E = 1'b1;
        sb.push_back(ev(0, 0, 1, 1, 0, 0, 1, 1));
      end else if (i == 11) begin
        McStart_E = 1'b1; McDone = 1'b1;
        sb.push_back(ev(0, 0, 0, 0, 0, 0, 0, 1));
      end else if (i == 12) begin
        rst = 1'b1;
        sb.push_back(ev(0, 0, 0, 0, 1, 1, 0, 1));
      end else begin
        sb.push_back(ev(0, 0, 0, 0, 0, 0, 0, 0));
      end
      @(negedge clk);
      e = sb.pop_front(); total++;
      if (obs() !== e) begin
        bad++;
        $display("FAIL wdog[%0d] got=%b exp=%b", i, obs(), e);
      end
    end
  endtask

  task automatic test_counters();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1; idle();
      case (i)
        0: rst = 1'b1;
        1, 3, 5: set_lu(2'b01, 5'd9, 5'd9, 5'd1);
        4, 6: PCSrc_E = 1'b1;
        7: begin
`ifdef HAZARD_PERF_CNT_EN
          cq.push_back(3); cq.push_back(5);
`else
          cq.push_back(0); cq.push_back(0);
`endif
        end
        default: ;
      endcase
    end
    @(negedge clk);
    total++;
    if (StallCnt !== CNT_W'(cq[0])) begin
      bad++;
      $display("FAIL stall_cnt got=%0d exp=%0d", StallCnt, cq[0]);
    end
    total++;
    if (FlushCnt !== CNT_W'(cq[1])) begin
      bad++;
      $display("FAIL flush_cnt got=%0d exp=%0d", FlushCnt, cq[1]);
    end
    cq.delete();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    test_reset();
    test_forward();
    test_load_use();
    test_branch();
    test_multicycle();
    test_k1();
    test_watchdog();
    test_counters();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
